// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared constants for the pipeline hazard controller.
//   REG_W           : register-number width
//   TUSE_NONE       : Tuse code meaning the operand is never read
//   TNEW_0..TNEW_2  : Tnew encodings (cycles until a result is ready)
//   MULT_CYCLES_DEF : default mult/multu busy length
//   DIV_CYCLES_DEF  : default div/divu busy length
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int         REG_W           = 5;
    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam logic [1:0] TNEW_0          = 2'd0;
    localparam logic [1:0] TNEW_1          = 2'd1;
    localparam logic [1:0] TNEW_2          = 2'd2;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_cnt.sv
// ---------------------------------------------------------------------------
// md_busy_cnt
// Load/decrement busy counter for the multi-cycle mult/div unit.
//   clk       : pipeline clock
//   reset     : asynchronous active-low reset
//   md_start  : mult/div issue in E this cycle
//   md_is_div : 1 = div, 0 = mult (qualifies md_start)
//   int_req   : M-stage exception; a same-cycle issue is flushed, no load
//   md_busy   : counter != 0
// ---------------------------------------------------------------------------
module md_busy_cnt
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    input  logic int_req,
    output logic md_busy
);

    logic [CNT_W-1:0] cnt;

    // An interrupt never cancels an already-running operation; it only
    // suppresses a load for the instruction being flushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (md_start && !int_req) begin
            cnt <= md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign md_busy = (cnt != '0);

`ifndef SYNTHESIS
    // D stalls while busy, so a new issue on a running counter is a
    // datapath bug; the reload above still lets the newest start win.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(md_start && !int_req && (cnt != '0)))
                else $error("md_busy_cnt: md_start while counter running");
        end
    end
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush controller for the 5-stage pipeline. Drives en/clear of the
// FD/DE/EM/MW registers and the PC enable from Tuse/Tnew data hazards,
// the mult/div busy counter and M-stage interrupt requests.
//   clk, reset              : clock, async active-low reset
//   D_rs/D_rt, *_tuse       : D-stage sources and their Tuse
//   D_is_md                 : D-stage instruction uses HI/LO / mult-div
//   E_dst/E_tnew, M_dst/M_tnew : in-flight producers
//   md_start, md_is_div     : E-stage mult/div issue
//   int_req                 : M-stage exception taken (overrides stall)
//   stall, md_busy          : hazard status
//   pc_en, FD_en, *_clear, *_en : stage register controls
// Optional macro PIPE_STALL_PERF_EN adds 32-bit stall_cnt / flush_cnt.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] D_rs,
    input  logic [REG_W-1:0] D_rt,
    input  logic [1:0]       D_rs_tuse,
    input  logic [1:0]       D_rt_tuse,
    input  logic             D_is_md,
    input  logic [REG_W-1:0] E_dst,
    input  logic [1:0]       E_tnew,
    input  logic [REG_W-1:0] M_dst,
    input  logic [1:0]       M_tnew,
    input  logic             md_start,
    input  logic             md_is_div,
    input  logic             int_req,
    output logic             stall,
    output logic             md_busy,
    output logic             pc_en,
    output logic             FD_en,
    output logic             FD_clear,
    output logic             DE_clear,
    output logic             EM_clear,
    output logic             MW_clear,
    output logic             DE_en,
    output logic             EM_en,
    output logic             MW_en
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    logic stall_rs;
    logic stall_rt;
    logic stall_md;

    // Tuse = 3 can never lose against Tnew <= 2, and $0 is never a hazard.
    assign stall_rs = (D_rs != '0) &&
                      (((E_dst == D_rs) && (E_tnew > D_rs_tuse)) ||
                       ((M_dst == D_rs) && (M_tnew > D_rs_tuse)));
    assign stall_rt = (D_rt != '0) &&
                      (((E_dst == D_rt) && (E_tnew > D_rt_tuse)) ||
                       ((M_dst == D_rt) && (M_tnew > D_rt_tuse)));
    assign stall_md = D_is_md && (md_start || md_busy);

    assign stall    = (stall_rs || stall_rt || stall_md) && !int_req;

    // On int_req the PC must load the handler vector, so it stays enabled
    // while every stage register is flushed.
    assign pc_en    = !stall;
    assign FD_en    = !stall;
    assign FD_clear = int_req;
    assign DE_clear = stall || int_req;
    assign EM_clear = int_req;
    assign MW_clear = int_req;
    assign DE_en    = 1'b1;
    assign EM_en    = 1'b1;
    assign MW_en    = 1'b1;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .int_req   (int_req),
        .md_busy   (md_busy)
    );

`ifdef PIPE_STALL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall)   stall_cnt <= stall_cnt + 32'd1;
            if (int_req) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Scoreboard bench: the stimulus process pushes the expected output vector
// for each cycle; a monitor on the falling edge pops and compares.
// Output vector order:
//   {stall, md_busy, pc_en, FD_en, FD_clear, DE_clear, EM_clear, MW_clear,
//    DE_en, EM_en, MW_en}
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_dst, M_dst;
    logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic       D_is_md, md_start, md_is_div, int_req;
    logic       stall, md_busy, pc_en, FD_en, FD_clear, DE_clear;
    logic       EM_clear, MW_clear, DE_en, EM_en, MW_en;
`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .D_is_md(D_is_md), .E_dst(E_dst), .E_tnew(E_tnew),
        .M_dst(M_dst), .M_tnew(M_tnew),
        .md_start(md_start), .md_is_div(md_is_div), .int_req(int_req),
        .stall(stall), .md_busy(md_busy), .pc_en(pc_en), .FD_en(FD_en),
        .FD_clear(FD_clear), .DE_clear(DE_clear), .EM_clear(EM_clear),
        .MW_clear(MW_clear), .DE_en(DE_en), .EM_en(EM_en), .MW_en(MW_en)
`ifdef PIPE_STALL_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [10:0] exp_q[$];
    int          cyc_q[$];

    // Reference model state: the last cycle in which md_busy is high.
    int cyc        = 0;
    int busy_until = -1;

    function automatic logic [10:0] dut_vec();
        return {stall, md_busy, pc_en, FD_en, FD_clear, DE_clear,
                EM_clear, MW_clear, DE_en, EM_en, MW_en};
    endfunction

    function automatic bit src_hazard(int r, int tuse);
        if (r == 0) return 1'b0;
        if (int'(E_dst) == r && int'(E_tnew) > tuse) return 1'b1;
        if (int'(M_dst) == r && int'(M_tnew) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [10:0] model_vec();
        bit busy, stl;
        bit pc, fd, fdc, dec, emc, mwc;
        busy = (cyc <= busy_until);
        stl  = (src_hazard(int'(D_rs), int'(D_rs_tuse)) ||
                src_hazard(int'(D_rt), int'(D_rt_tuse)) ||
                (D_is_md && (md_start || busy))) && !int_req;
        if (int_req) begin
            pc = 1; fd = 1; fdc = 1; dec = 1; emc = 1; mwc = 1;
        end else if (stl) begin
            pc = 0; fd = 0; fdc = 0; dec = 1; emc = 0; mwc = 0;
        end else begin
            pc = 1; fd = 1; fdc = 0; dec = 0; emc = 0; mwc = 0;
        end
        return {stl, busy, pc, fd, fdc, dec, emc, mwc, 1'b1, 1'b1, 1'b1};
    endfunction

    task automatic check_now(string name, logic [10:0] act, logic [10:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        D_rs = 0; D_rt = 0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; D_is_md = 0;
        E_dst = 0; E_tnew = 0; M_dst = 0; M_tnew = 0;
        md_start = 0; md_is_div = 0; int_req = 0;
    endtask

    // Inputs for cycle 'cyc' must already be set; push expectation, then
    // advance the model across the closing clock edge.
    task automatic commit_cycle();
        exp_q.push_back(model_vec());
        cyc_q.push_back(cyc);
        if (md_start && !int_req)
            busy_until = cyc + (md_is_div ? DIV_N : MULT_N);
        cyc++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            int          c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check_now($sformatf("outs cyc=%0d", c), dut_vec(), e);
        end
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        #12;
        check_now("reset_outs", dut_vec(), 11'b00110000111);
        reset = 1'b1;

        // Load-use on rs, then forwarded from M, then resolved.
        next_cycle(); idle_inputs();
        E_dst = 5; E_tnew = 2; D_rs = 5; D_rs_tuse = 0; commit_cycle();
        next_cycle(); idle_inputs();
        M_dst = 5; M_tnew = 1; D_rs = 5; D_rs_tuse = 0; commit_cycle();
        next_cycle(); idle_inputs();
        M_dst = 5; M_tnew = 0; D_rs = 5; D_rs_tuse = 0; commit_cycle();

        // $zero never stalls; rt hazard path.
        next_cycle(); idle_inputs();
        E_dst = 0; E_tnew = 2; D_rs = 0; D_rs_tuse = 0; commit_cycle();
        next_cycle(); idle_inputs();
        E_dst = 7; E_tnew = 1; D_rt = 7; D_rt_tuse = 0; commit_cycle();

        // Mult with D_is_md held through cycle 6.
        for (int i = 0; i <= 6; i++) begin
            next_cycle(); idle_inputs();
            D_is_md = 1; md_start = (i == 0); commit_cycle();
        end

        // Div, interrupt three cycles later, counter keeps running.
        for (int i = 0; i <= 11; i++) begin
            next_cycle(); idle_inputs();
            md_start = (i == 0); md_is_div = 1;
            D_is_md = (i == 3); int_req = (i == 3); commit_cycle();
        end

        // Issue flushed by a same-cycle interrupt.
        next_cycle(); idle_inputs();
        md_start = 1; int_req = 1; D_is_md = 1; commit_cycle();
        next_cycle(); idle_inputs();
        D_is_md = 1; commit_cycle();

        // Reset in the middle of a mult: md_busy must drop without an edge.
        next_cycle(); idle_inputs(); md_start = 1; commit_cycle();
        next_cycle(); idle_inputs(); commit_cycle();
        next_cycle(); idle_inputs();
        #1;
        reset = 1'b0;
        #1;
        check_now("async_reset_busy", {10'd0, md_busy}, 11'd0);
        busy_until = -1;
        commit_cycle();
        @(negedge clk);
        #1;
        reset = 1'b1;
        next_cycle(); idle_inputs(); D_is_md = 1; commit_cycle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            next_cycle(); idle_inputs();
            D_rs      = 5'($urandom_range(0, 3));
            D_rt      = 5'($urandom_range(0, 3));
            D_rs_tuse = 2'($urandom_range(0, 3));
            D_rt_tuse = 2'($urandom_range(0, 3));
            E_dst     = 5'($urandom_range(0, 3));
            E_tnew    = 2'($urandom_range(0, 2));
            M_dst     = 5'($urandom_range(0, 3));
            M_tnew    = 2'($urandom_range(0, 2));
            D_is_md   = ($urandom_range(0, 2) == 0);
            int_req   = ($urandom_range(0, 7) == 0);
            md_is_div = 1'($urandom_range(0, 1));
            md_start  = (cyc > busy_until) && ($urandom_range(0, 5) == 0);
            commit_cycle();
        end

        next_cycle(); idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check_now("scoreboard_drained", 11'(exp_q.size()), 11'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Generates en/clear for the FD, DE, EM and MW pipeline registers and the PC enable.
- Decides from Tuse/Tnew data hazards, a multi-cycle mult/div busy counter and M-stage interrupt/exception requests.
- Sits beside the datapath. Its outputs wire directly to each stage register's en/clear inputs.

Parameters:
- MULT_CYCLES, 5: busy cycles after a mult/multu issue.
- DIV_CYCLES, 10: busy cycles after a div/divu issue.
- CNT_W, 4: busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- D_rs  in  5  D-stage rs register number.
- D_rt  in  5  D-stage rt register number.
- D_rs_tuse  in  2  cycles until D-stage instruction needs rs (3 = not used).
- D_rt_tuse  in  2  cycles until D-stage instruction needs rt (3 = not used).
- D_is_md  in  1  D-stage instruction touches HI/LO or the mult/div unit.
- E_dst  in  5  E-stage destination register (0 = none).
- E_tnew  in  2  cycles until E-stage result is ready.
- M_dst  in  5  M-stage destination register.
- M_tnew  in  2  cycles until M-stage result is ready.
- md_start  in  1  E-stage mult/div issue this cycle.
- md_is_div  in  1  qualifies md_start: 1 = div, 0 = mult.
- int_req  in  1  M-stage exception/interrupt taken this cycle.
- stall  out  1  pipeline stall (combinational).
- md_busy  out  1  mult/div unit busy (registered counter != 0).
- pc_en  out  1  PC register enable.
- FD_en  out  1  FD register enable.
- FD_clear  out  1  FD register synchronous clear.
- DE_clear  out  1  DE register clear (bubble insert).
- EM_clear  out  1  EM register clear.
- MW_clear  out  1  MW register clear.
- DE_en  out  1  DE register enable.
- EM_en  out  1  EM register enable.
- MW_en  out  1  MW register enable.

Behaviour:
- Reset (reset=0, asynchronous): busy counter = 0, so md_busy = 0. All other outputs are combinational and settle to: stall=0, pc_en=FD_en=1, all clears=0, DE_en=EM_en=MW_en=1 (absent other inputs).
- Data hazard on rs: stall_rs = (D_rs!=0) && ((E_dst==D_rs && E_tnew>D_rs_tuse) || (M_dst==D_rs && M_tnew>D_rs_tuse)). stall_rt is identical using D_rt and D_rt_tuse.
  - Register $0 never stalls.
  - Tuse=3 never stalls, since Tnew is at most 2.
- MD hazard: stall_md = D_is_md && (md_start || md_busy).
- Combined: stall = (stall_rs || stall_rt || stall_md) && !int_req. int_req overrides stall.
- Normal stall: pc_en=0, FD_en=0, DE_clear=1. EM and MW advance.
- int_req=1: pc_en=1 (handler vector loads), FD_en=1, FD_clear=DE_clear=EM_clear=MW_clear=1.
- DE_en, EM_en and MW_en are always 1.
- Busy counter, sequential:
  - On posedge clk with md_start && !int_req: load DIV_CYCLES if md_is_div, else MULT_CYCLES.
  - Otherwise, if count!=0, decrement by 1.
  - md_busy is high for exactly N cycles after the issue edge.
- md_start && int_req in the same cycle: the issuing instruction is flushed, so there is no load. The counter continues its current decrement.
- int_req while busy: an already-issued operation is committed. The counter keeps counting; it is not cancelled.
- md_start while count!=0 cannot occur, because D stalls. The RTL reloads anyway (new start wins), and a simulation assertion flags it.
- No wrap-around: the decrement saturates at 0.

Optional Feature:
- Macro: PIPE_STALL_PERF_EN.
- Defined:
  - Adds output stall_cnt (32 bits) and output flush_cnt (32 bits).
  - stall_cnt increments on every cycle with stall=1; flush_cnt increments on every cycle with int_req=1.
  - Both wrap modulo 2^32 and reset asynchronously to 0.
- Undefined: neither port nor counter exists, and the block is otherwise identical.

Decomposition:
- Shared package/header holds:
  - TUSE_NONE=3 and the Tnew encodings (0..2).
  - MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=10.
  - Register-number width REG_W=5.
- Natural sub-module: md_busy_cnt, containing the load/decrement counter and md_busy.
- Hazard comparison stays inline as combinational logic.

Test Plan:
- Load-use: E_dst=5, E_tnew=2, D_rs=5, D_rs_tuse=0 -> stall=1, pc_en=0, FD_en=0, DE_clear=1. Next cycle M_dst=5, M_tnew=1 -> stall=1. Then M_tnew=0 -> stall=0.
- $zero: E_dst=0, E_tnew=2, D_rs=0, D_rs_tuse=0 -> stall=0.
- Mult: md_start=1, md_is_div=0 at cycle 0 with D_is_md=1 held -> md_busy=1 for cycles 1..5 and stall=1 for cycles 0..5; cycle 6 stall=0.
- Div then int: div issued at cycle 0, int_req=1 at cycle 3 -> that cycle all clears=1, pc_en=1, stall=0. md_busy stays 1 through cycle 10.
- Start flushed: md_start=1 with int_req=1 -> md_busy stays 0 next cycle.
- Reset mid-count: mult issued, reset driven 0 at cycle 2 between edges -> md_busy=0 immediately, no clock edge needed. After release, D_is_md=1 gives stall=0.
